axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 subordinate (responder) for the core's AXI master ports: accepts read and write bursts on
//  axi_r_m2s_t / axi_w_m2s_t and answers on axi_r_s2m_t / axi_w_s2m_t, backed by a word-wide SRAM.
//  Sits in the simulation top in place of external memory; used to exercise icache/dcache refills.
// PARAMETERS
//  AddrBits   10           log2 of SRAM depth in 32-bit words (1024 words = 4 KiB)
//  RespDelay  0            extra wait cycles between AR accept and first rvalid (0..15)
//  BaseAddr   RstAddr      byte address mapped to word 0
// PORTS
//  clock        in   1    single clock, all logic on posedge
//  reset        in   1    synchronous, active-high
//  r_m2s_i      in   47   axi_r_m2s_t: arvalid, araddr, arlen, arsize, arburst, rready
//  r_s2m_o      out  35   axi_r_s2m_t: arready, rvalid, rdata, rlast
//  w_m2s_i      in   85   axi_w_m2s_t: awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready
//  w_s2m_o      out  3    axi_w_s2m_t: awready, wready, bvalid
//  wlast_err_o  out  1    1-cycle pulse: wlast value disagreed with beat count on an accepted W beat
// BEHAVIOUR
//  Reset: both FSMs -> IDLE; all s2m outputs and wlast_err_o = 0 while reset high. SRAM not cleared.
//  Read and write channels are independent FSMs; both may be active simultaneously.
//  Address map: word index = (addr - BaseAddr)[AddrBits+1:2]; out-of-range addresses wrap mod depth.
//  Beat step: INCR(01) and WRAP(10) -> addr += (1<<size); FIXED(00) -> addr unchanged. WRAP treated as INCR.
//  Narrow transfers: rdata always full aligned word; master selects byte lanes. Writes use wstrb only.
//  Read FSM: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE
//   R_IDLE: arready=1. arvalid&arready: latch addr/len/size/burst, beat cnt=0;
//           -> R_WAIT if RespDelay>0 (delay ctr loaded RespDelay), else R_DATA.
//   R_WAIT: arready=0, rvalid=0; ctr decrements; ctr==1 -> R_DATA.
//   R_DATA: rvalid=1, rdata registered (loaded on entry and on each handshake from next addr);
//           rlast = (cnt==len). rvalid&rready: cnt++, addr steps; if rlast -> R_IDLE.
//           rvalid/rdata/rlast held stable while rready=0.
//  Latency: RespDelay=0 -> first rvalid the cycle after AR handshake; 1 beat/cycle under rready=1.
//  Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE
//   W_IDLE: awready=1. awvalid&awready: latch addr/len/size/burst, cnt=0 -> W_DATA.
//   W_DATA: wready=1. wvalid&wready: write bytes where wstrb[i]=1 at current addr; cnt++, addr steps.
//           Burst ends on beat cnt==awlen regardless of wlast -> W_RESP.
//           wlast != (cnt==awlen) on an accepted beat -> wlast_err_o pulses next cycle.
//   W_RESP: bvalid=1 until bready; bvalid&bready -> W_IDLE. awready=0 until back in W_IDLE.
//  AW and W never accepted in the same cycle (W only in W_DATA); W beats before AW are stalled (wready=0).
//  Same-cycle read sample and write to same word: read returns old data; write visible next cycle.
//  Max burst 256 beats (len 8 bit); cnt is 8 bit, no overflow possible.
//  Reset mid-burst: FSMs abort to IDLE next cycle, no bvalid/rlast emitted; partial writes remain in SRAM.
// TESTING
//  1 Write single: aw addr=0x8000_0000 len=0, w 0xDEADBEEF strb=F wlast=1 -> bvalid 1 cycle later; read back 0xDEADBEEF rlast=1.
//  2 Read INCR burst len=3 (4 beats) from 0x8000_0010 preloaded 1,2,3,4 -> rdata 1,2,3,4, rlast on beat 4 only, rready toggled every other cycle holds data.
//  3 Byte strobes: write 0x11223344 strb=0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
//  4 FIXED burst len=3 write 5,6,7,8 to same addr -> readback 8; wlast asserted on beat 2 -> wlast_err_o pulse.
//  5 RespDelay=3: AR handshake at cycle t -> first rvalid at t+4; concurrent write burst completes unaffected.
//  6 Reset asserted mid read burst (beat 2 of 8) -> next cycle rvalid=0, arready=1; new read returns correct data.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-wide SRAM; read and write channels run as independent FSMs.
// Flat channel vectors pack fields MSB-first in the order listed on each port.
module axi_sram_slave #(
    parameter int unsigned AddrBits  = 10,
    parameter int unsigned RespDelay = 0,
    parameter logic [31:0] BaseAddr  = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [46:0] r_m2s_i,
    output logic [34:0] r_s2m_o,
    input  logic [84:0] w_m2s_i,
    output logic [2:0]  w_s2m_o,
    output logic        wlast_err_o
);
    localparam int unsigned Depth = 1 << AddrBits;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic        arvalid, rready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    assign {arvalid, araddr, arlen, arsize, arburst, rready} = r_m2s_i;

    logic        awvalid, wvalid, wlast, bready;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  wstrb;
    assign {awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready} = w_m2s_i;

    logic [31:0] mem [Depth];

    function automatic logic [AddrBits-1:0] word_idx(input logic [31:0] addr);
        return AddrBits'((addr - BaseAddr) >> 2);
    endfunction

    function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + (32'd1 << size);
    endfunction

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d, rdata_q;
    logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [3:0]  rdly_q, rdly_d;
    logic        r_load, arready, rvalid, rlast;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        mem_we, awready, wready, bvalid, wlast_err_q, wlast_err_d;

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdly_d    = rdly_q;
        r_load    = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    raddr_d  = araddr;
                    rlen_d   = arlen;
                    rsize_d  = arsize;
                    rburst_d = arburst;
                    rcnt_d   = '0;
                    if (RespDelay > 0) begin
                        r_state_d = R_WAIT;
                        rdly_d    = 4'(RespDelay);
                    end else begin
                        r_state_d = R_DATA;
                        r_load    = 1'b1;
                    end
                end
            end
            R_WAIT: begin
                rdly_d = rdly_q - 4'd1;
                if (rdly_q == 4'd1) begin
                    r_state_d = R_DATA;
                    r_load    = 1'b1;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (rcnt_q == rlen_q);
                if (rready) begin
                    rcnt_d  = rcnt_q + 8'd1;
                    raddr_d = step_addr(raddr_q, rsize_q, rburst_q);
                    if (rlast) r_state_d = R_IDLE;
                    else       r_load    = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wcnt_d      = wcnt_q;
        mem_we      = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        wlast_err_d = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wsize_d   = awsize;
                    wburst_d  = awburst;
                    wcnt_d    = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we      = 1'b1;
                    wlast_err_d = (wlast != (wcnt_q == wlen_q));
                    wcnt_d      = wcnt_q + 8'd1;
                    waddr_d     = step_addr(waddr_q, wsize_q, wburst_q);
                    if (wcnt_q == wlen_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            wlast_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    always_ff @(posedge clock) begin
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
        rcnt_q   <= rcnt_d;
        rdly_q   <= rdly_d;
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
        wcnt_q   <= wcnt_d;
    end

    // Read samples the pre-write contents, so a same-cycle write to the word shows up next cycle.
    always_ff @(posedge clock) begin
        if (r_load) rdata_q <= mem[word_idx(raddr_d)];
        if (mem_we && !reset) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign r_s2m_o     = reset ? '0 : {arready, rvalid, rdata_q, rlast};
    assign w_s2m_o     = reset ? '0 : {awready, wready, bvalid};
    assign wlast_err_o = reset ? 1'b0 : wlast_err_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a byte-level memory model feeds a read-data scoreboard queue.
module tb_axi_sram_slave;
    localparam logic [31:0] Base = 32'h8000_0000;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;

    logic        clock = 1'b0;
    logic        reset;
    logic [46:0] r_m2s [2];
    logic [34:0] r_s2m [2];
    logic [84:0] w_m2s [2];
    logic [2:0]  w_s2m [2];
    logic        werr  [2];

    typedef struct { logic [31:0] data; logic last; } exp_t;
    exp_t        sb [$];
    logic [31:0] model [2][1024];
    logic [31:0] wbuf  [16];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    axi_sram_slave #(.AddrBits(10), .RespDelay(0), .BaseAddr(Base)) dut0 (
        .clock(clock), .reset(reset), .r_m2s_i(r_m2s[0]), .r_s2m_o(r_s2m[0]),
        .w_m2s_i(w_m2s[0]), .w_s2m_o(w_s2m[0]), .wlast_err_o(werr[0]));

    axi_sram_slave #(.AddrBits(10), .RespDelay(3), .BaseAddr(Base)) dut1 (
        .clock(clock), .reset(reset), .r_m2s_i(r_m2s[1]), .r_s2m_o(r_s2m[1]),
        .w_m2s_i(w_m2s[1]), .w_s2m_o(w_s2m[1]), .wlast_err_o(werr[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - Base) >> 2;
        return int'(o[9:0]);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] burst);
        return (burst == FIXED) ? a : a + 32'd4;
    endfunction

    // Beats come from wbuf; wlast is driven on beat last_at (normally == len).
    task automatic axi_write(input int s, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input int last_at);
        int n;
        logic [31:0] a;
        w_m2s[s] = {1'b1, addr, len, 3'd2, burst, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0};
        n = 0;
        while (!w_s2m[s][2] && n < 50) begin @(negedge clock); n++; end
        chkb("awready", w_s2m[s][2], 1'b1);
        @(negedge clock);
        w_m2s[s][84] = 1'b0;
        chkb("awready_busy", w_s2m[s][2], 1'b0);
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            w_m2s[s][38]   = 1'b1;
            w_m2s[s][37:6] = wbuf[k];
            w_m2s[s][5:2]  = strb;
            w_m2s[s][1]    = (k == last_at);
            n = 0;
            while (!w_s2m[s][1] && n < 50) begin @(negedge clock); n++; end
            chkb("wready", w_s2m[s][1], 1'b1);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[s][widx(a)][8*b +: 8] = wbuf[k][8*b +: 8];
            a = step(a, burst);
            @(negedge clock);
            chkb("wlast_err", werr[s], (k == last_at) != (k == int'(len)));
        end
        w_m2s[s][38] = 1'b0;
        w_m2s[s][1]  = 1'b0;
        chkb("bvalid", w_s2m[s][0], 1'b1);
        w_m2s[s][0] = 1'b1;
        @(negedge clock);
        w_m2s[s][0] = 1'b0;
        chkb("bvalid_drop", w_s2m[s][0], 1'b0);
        chkb("awready_back", w_s2m[s][2], 1'b1);
    endtask

    // lat: negedges from AR handshake to first rvalid. abort_after >= 0 stops after that many beats.
    task automatic axi_read(input int s, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit toggle, input int lat,
                            input int abort_after);
        int n, got;
        logic [31:0] a;
        exp_t e;
        logic rr;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = model[s][widx(a)];
            e.last = (k == int'(len));
            sb.push_back(e);
            a = step(a, burst);
        end
        r_m2s[s] = {1'b1, addr, len, 3'd2, burst, 1'b0};
        n = 0;
        while (!r_s2m[s][34] && n < 50) begin @(negedge clock); n++; end
        chkb("arready", r_s2m[s][34], 1'b1);
        @(negedge clock);
        r_m2s[s][46] = 1'b0;
        n = 1;
        while (!r_s2m[s][33] && n < 60) begin @(negedge clock); n++; end
        chk("rvalid_latency", n, lat);
        got = 0;
        n = 0;
        while (sb.size() > 0 && n < 200 && got != abort_after) begin
            rr = !toggle || (n % 2 == 1);
            r_m2s[s][0] = rr;
            if (r_s2m[s][33]) begin
                chk("rdata", r_s2m[s][32:1], sb[0].data);
                chkb("rlast", r_s2m[s][0], sb[0].last);
                if (rr) begin
                    void'(sb.pop_front());
                    got++;
                end
            end
            @(negedge clock);
            n++;
        end
        r_m2s[s][0] = 1'b0;
        if (abort_after < 0) begin
            chk("beats_left", sb.size(), 0);
            chkb("rvalid_idle", r_s2m[s][33], 1'b0);
            chkb("arready_idle", r_s2m[s][34], 1'b1);
        end
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            r_m2s[s] = '0;
            w_m2s[s] = '0;
        end
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            chkb("rst_r_s2m_zero", r_s2m[s] === '0, 1'b1);
            chkb("rst_w_s2m_zero", w_s2m[s] === '0, 1'b1);
            chkb("rst_wlast_err", werr[s], 1'b0);
        end
        reset = 1'b0;
        @(negedge clock);
        chkb("post_rst_arready", r_s2m[0][34], 1'b1);
        chkb("post_rst_awready", w_s2m[0][2], 1'b1);

        // single write and readback, then the same word through an address one depth higher
        wbuf[0] = 32'hDEAD_BEEF;
        axi_write(0, Base, 8'd0, INCR, 4'hF, 0);
        axi_read(0, Base, 8'd0, INCR, 1'b0, 1, -1);
        axi_read(0, Base + 32'h1000, 8'd0, INCR, 1'b0, 1, -1);

        // INCR burst with rready toggling
        for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
        axi_write(0, Base + 32'h10, 8'd3, INCR, 4'hF, 3);
        axi_read(0, Base + 32'h10, 8'd3, INCR, 1'b1, 1, -1);

        // byte strobes over an all-ones word
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write(0, Base + 32'h20, 8'd0, INCR, 4'hF, 0);
        wbuf[0] = 32'h1122_3344;
        axi_write(0, Base + 32'h20, 8'd0, INCR, 4'b0101, 0);
        axi_read(0, Base + 32'h20, 8'd0, INCR, 1'b0, 1, -1);

        // FIXED burst with early wlast: pulses on beat 2 and on the real last beat
        for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 5);
        axi_write(0, Base + 32'h30, 8'd3, FIXED, 4'hF, 2);
        axi_read(0, Base + 32'h30, 8'd1, FIXED, 1'b0, 1, -1);

        // RespDelay=3 instance: read latency with a concurrent write burst
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA000_0000 + 32'(k);
        axi_write(1, Base + 32'h40, 8'd3, INCR, 4'hF, 3);
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hB000_0000 + 32'(k);
        fork
            axi_read(1, Base + 32'h40, 8'd3, INCR, 1'b0, 4, -1);
            axi_write(1, Base + 32'h80, 8'd3, INCR, 4'hF, 3);
        join
        axi_read(1, Base + 32'h80, 8'd3, INCR, 1'b0, 4, -1);

        // reset in the middle of an 8-beat read
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hC000_0100 + 32'(k);
        axi_write(0, Base + 32'h100, 8'd7, INCR, 4'hF, 7);
        axi_read(0, Base + 32'h100, 8'd7, INCR, 1'b0, 1, 2);
        reset = 1'b1;
        @(negedge clock);
        chkb("midrst_r_s2m_zero", r_s2m[0] === '0, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        chkb("midrst_rvalid", r_s2m[0][33], 1'b0);
        chkb("midrst_arready", r_s2m[0][34], 1'b1);
        axi_read(0, Base + 32'h100, 8'd7, INCR, 1'b0, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
